// File: rtl/alu_pkg.sv
// Shared ALU definitions: control encodings, ALUOp encodings and datapath width.
package alu_pkg;

   localparam int XLEN       = 64;
   localparam int ALU_CTRL_W = 4;

   localparam logic [ALU_CTRL_W-1:0] AND_Oper  = 4'b0000;
   localparam logic [ALU_CTRL_W-1:0] OR_Oper   = 4'b0001;
   localparam logic [ALU_CTRL_W-1:0] ADD_Oper  = 4'b0010;
   localparam logic [ALU_CTRL_W-1:0] SRL_Oper  = 4'b0011;
   localparam logic [ALU_CTRL_W-1:0] XOR_Oper  = 4'b0100;
   localparam logic [ALU_CTRL_W-1:0] SLL_Oper  = 4'b0101;
   localparam logic [ALU_CTRL_W-1:0] SUB_Oper  = 4'b0110;
   localparam logic [ALU_CTRL_W-1:0] SRA_Oper  = 4'b0111;
   localparam logic [ALU_CTRL_W-1:0] SLT_Oper  = 4'b1000;
   localparam logic [ALU_CTRL_W-1:0] SLTU_Oper = 4'b1001;

   typedef enum logic [1:0] {
      ALUOP_LS  = 2'b00,
      ALUOP_BR  = 2'b01,
      ALUOP_R   = 2'b10,
      ALUOP_IMM = 2'b11
   } alu_op_e;

endpackage

// File: rtl/alu_control_decode.sv
// Combinational ALUOp/funct3/funct7[5] to 4-bit ALU control decode.
module alu_control_decode
   import alu_pkg::*;
(
   input  logic [1:0] alu_op_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7_b5_i,
   output logic [3:0] alu_control_o
);

   always_comb begin
      alu_control_o = ADD_Oper;
      case (alu_op_e'(alu_op_i))
         ALUOP_LS: alu_control_o = ADD_Oper;
         ALUOP_BR: alu_control_o = SUB_Oper;
         default: begin
            case (funct3_i)
               // Immediate forms have no SUBI, so bit 30 only selects SUB for R-type
               3'b000:  alu_control_o = (alu_op_e'(alu_op_i) == ALUOP_R && funct7_b5_i) ? SUB_Oper : ADD_Oper;
               3'b001:  alu_control_o = SLL_Oper;
               3'b010:  alu_control_o = SLT_Oper;
               3'b011:  alu_control_o = SLTU_Oper;
               3'b100:  alu_control_o = XOR_Oper;
               3'b101:  alu_control_o = funct7_b5_i ? SRA_Oper : SRL_Oper;
               3'b110:  alu_control_o = OR_Oper;
               default: alu_control_o = AND_Oper;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX pipeline register with ALU control decode, operand forwarding and load-use detection.
module id_ex_alu_issue #(
   parameter int XLEN       = 64,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic [XLEN-1:0]       id_rs1_data,
   input  logic [XLEN-1:0]       id_rs2_data,
   input  logic [XLEN-1:0]       id_imm,
   input  logic [1:0]            id_alu_op,
   input  logic                  id_alu_src,
   input  logic [2:0]            id_funct3,
   input  logic                  id_funct7_b5,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  ex_hold,
   input  logic                  flush,
   input  logic [REG_ADDR_W-1:0] ex_mem_rd,
   input  logic [REG_ADDR_W-1:0] mem_wb_rd,
   input  logic                  ex_mem_reg_write,
   input  logic                  mem_wb_reg_write,
   input  logic [XLEN-1:0]       ex_mem_result,
   input  logic [XLEN-1:0]       mem_wb_result,
   output logic                  load_use_stall,
   output logic                  ex_valid,
   output logic                  ex_reg_write,
   output logic                  ex_mem_read,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic [XLEN-1:0]       alu_in1,
   output logic [XLEN-1:0]       alu_in2,
   output logic [3:0]            alu_control,
   output logic [XLEN-1:0]       ex_store_data
);

   import alu_pkg::*;

   logic                  valid_q, valid_d;
   logic                  regWrite_q, regWrite_d;
   logic                  memRead_q, memRead_d;
   logic                  aluSrc_q, aluSrc_d;
   logic [REG_ADDR_W-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
   logic [XLEN-1:0]       rs1Data_q, rs1Data_d, rs2Data_q, rs2Data_d, imm_q, imm_d;
   logic [3:0]            control_q, control_d;
   logic [3:0]            decodedControl;
   logic [XLEN-1:0]       fwdRs1, fwdRs2;

   alu_control_decode u_decode (
      .alu_op_i      (id_alu_op),
      .funct3_i      (id_funct3),
      .funct7_b5_i   (id_funct7_b5),
      .alu_control_o (decodedControl)
   );

   // Conservative: rs2 is compared even for instructions that never read it
   assign load_use_stall = id_valid & valid_q & memRead_q & (rd_q != '0) &
                           ((rd_q == id_rs1) | (rd_q == id_rs2));

   always_comb begin
      valid_d    = valid_q;
      regWrite_d = regWrite_q;
      memRead_d  = memRead_q;
      aluSrc_d   = aluSrc_q;
      rd_d       = rd_q;
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      rs1Data_d  = rs1Data_q;
      rs2Data_d  = rs2Data_q;
      imm_d      = imm_q;
      control_d  = control_q;
      // Flush overrides hold so a redirect can never leave a stale instruction in EX
      if (flush || (!ex_hold && load_use_stall)) begin
         valid_d    = 1'b0;
         regWrite_d = 1'b0;
         memRead_d  = 1'b0;
         aluSrc_d   = 1'b0;
         rd_d       = '0;
         rs1_d      = '0;
         rs2_d      = '0;
         rs1Data_d  = '0;
         rs2Data_d  = '0;
         imm_d      = '0;
         control_d  = AND_Oper;
      end else if (!ex_hold) begin
         valid_d    = id_valid;
         regWrite_d = id_valid & id_reg_write;
         memRead_d  = id_valid & id_mem_read;
         aluSrc_d   = id_alu_src;
         rd_d       = id_rd;
         rs1_d      = id_rs1;
         rs2_d      = id_rs2;
         rs1Data_d  = id_rs1_data;
         rs2Data_d  = id_rs2_data;
         imm_d      = id_imm;
         control_d  = decodedControl;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q    <= 1'b0;
         regWrite_q <= 1'b0;
         memRead_q  <= 1'b0;
         aluSrc_q   <= 1'b0;
         rd_q       <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rs1Data_q  <= '0;
         rs2Data_q  <= '0;
         imm_q      <= '0;
         control_q  <= AND_Oper;
      end else begin
         valid_q    <= valid_d;
         regWrite_q <= regWrite_d;
         memRead_q  <= memRead_d;
         aluSrc_q   <= aluSrc_d;
         rd_q       <= rd_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         rs1Data_q  <= rs1Data_d;
         rs2Data_q  <= rs2Data_d;
         imm_q      <= imm_d;
         control_q  <= control_d;
      end
   end

   // EX/MEM is the younger result, so it wins; x0 is never forwarded
   always_comb begin
      fwdRs1 = rs1Data_q;
      if (ex_mem_reg_write && (ex_mem_rd != '0) && (ex_mem_rd == rs1_q))
         fwdRs1 = ex_mem_result;
      else if (mem_wb_reg_write && (mem_wb_rd != '0) && (mem_wb_rd == rs1_q))
         fwdRs1 = mem_wb_result;
   end

   always_comb begin
      fwdRs2 = rs2Data_q;
      if (ex_mem_reg_write && (ex_mem_rd != '0) && (ex_mem_rd == rs2_q))
         fwdRs2 = ex_mem_result;
      else if (mem_wb_reg_write && (mem_wb_rd != '0) && (mem_wb_rd == rs2_q))
         fwdRs2 = mem_wb_result;
   end

   assign ex_valid      = valid_q;
   assign ex_reg_write  = regWrite_q;
   assign ex_mem_read   = memRead_q;
   assign ex_rd         = rd_q;
   assign alu_control   = control_q;
   assign alu_in1       = fwdRs1;
   assign alu_in2       = aluSrc_q ? imm_q : fwdRs2;
   assign ex_store_data = fwdRs2;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Directed self-checking bench for the ID/EX issue stage.
module tb_id_ex_alu_issue;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [63:0] id_rs1_data, id_rs2_data, id_imm;
   logic [1:0]  id_alu_op;
   logic        id_alu_src;
   logic [2:0]  id_funct3;
   logic        id_funct7_b5, id_reg_write, id_mem_read;
   logic        ex_hold, flush;
   logic [4:0]  ex_mem_rd, mem_wb_rd;
   logic        ex_mem_reg_write, mem_wb_reg_write;
   logic [63:0] ex_mem_result, mem_wb_result;
   logic        load_use_stall, ex_valid, ex_reg_write, ex_mem_read;
   logic [4:0]  ex_rd;
   logic [63:0] alu_in1, alu_in2, ex_store_data;
   logic [3:0]  alu_control;

   int compared   = 0;
   int mismatched = 0;

   id_ex_alu_issue #(.XLEN(64), .REG_ADDR_W(5)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_funct3(id_funct3),
      .id_funct7_b5(id_funct7_b5), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .ex_hold(ex_hold), .flush(flush),
      .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
      .ex_mem_reg_write(ex_mem_reg_write), .mem_wb_reg_write(mem_wb_reg_write),
      .ex_mem_result(ex_mem_result), .mem_wb_result(mem_wb_result),
      .load_use_stall(load_use_stall), .ex_valid(ex_valid),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_control(alu_control),
      .ex_store_data(ex_store_data)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] op, input logic [2:0] f3, input logic b5,
                                input logic src, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [63:0] d1, input logic [63:0] d2,
                                input logic [63:0] imm, input logic rw, input logic mr);
      id_valid     = 1'b1;
      id_alu_op    = op;
      id_funct3    = f3;
      id_funct7_b5 = b5;
      id_alu_src   = src;
      id_rs1       = rs1;
      id_rs2       = rs2;
      id_rd        = rd;
      id_rs1_data  = d1;
      id_rs2_data  = d2;
      id_imm       = imm;
      id_reg_write = rw;
      id_mem_read  = mr;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; ex_hold = 1'b0; flush = 1'b0;
      ex_mem_rd = '0; mem_wb_rd = '0; ex_mem_reg_write = 1'b0; mem_wb_reg_write = 1'b0;
      ex_mem_result = '0; mem_wb_result = '0;
      applyStimulus(2'b10, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0);
      id_valid = 1'b0;
      step(); step();
      checkOutput("reset_valid", 64'(ex_valid), 64'd0);
      checkOutput("reset_ctrl", 64'(alu_control), 64'd0);
      checkOutput("reset_in1", alu_in1, 64'd0);
      checkOutput("reset_in2", alu_in2, 64'd0);
      reset = 1'b0;

      $display("[TB] R-type SUB");
      applyStimulus(2'b10, 3'b000, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 64'd5, 64'd3, 64'd99, 1'b1, 1'b0);
      step();
      checkOutput("sub_ctrl", 64'(alu_control), 64'h6);
      checkOutput("sub_in1", alu_in1, 64'd5);
      checkOutput("sub_in2", alu_in2, 64'd3);
      checkOutput("sub_valid", 64'(ex_valid), 64'd1);
      checkOutput("sub_rd", 64'(ex_rd), 64'd3);
      checkOutput("sub_rw", 64'(ex_reg_write), 64'd1);

      $display("[TB] I-type SRAI and ADDI");
      applyStimulus(2'b11, 3'b101, 1'b1, 1'b1, 5'd4, 5'd5, 5'd6, 64'h8000, 64'h22, 64'd1, 1'b1, 1'b0);
      step();
      checkOutput("srai_ctrl", 64'(alu_control), 64'h7);
      checkOutput("srai_in2", alu_in2, 64'd1);
      checkOutput("srai_store", ex_store_data, 64'h22);
      applyStimulus(2'b11, 3'b000, 1'b1, 1'b1, 5'd4, 5'd5, 5'd6, 64'h8000, 64'h22, 64'd12, 1'b1, 1'b0);
      step();
      checkOutput("addi_b5_ctrl", 64'(alu_control), 64'h2);

      $display("[TB] Decode table");
      applyStimulus(2'b00, 3'b111, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0);
      step(); checkOutput("ls_ctrl", 64'(alu_control), 64'h2);
      id_alu_op = 2'b01; step(); checkOutput("br_ctrl", 64'(alu_control), 64'h6);
      id_alu_op = 2'b10; id_funct3 = 3'b101; id_funct7_b5 = 1'b0;
      step(); checkOutput("srl_ctrl", 64'(alu_control), 64'h3);
      id_funct3 = 3'b001; step(); checkOutput("sll_ctrl", 64'(alu_control), 64'h5);
      id_funct3 = 3'b010; step(); checkOutput("slt_ctrl", 64'(alu_control), 64'h8);
      id_funct3 = 3'b011; step(); checkOutput("sltu_ctrl", 64'(alu_control), 64'h9);
      id_funct3 = 3'b100; step(); checkOutput("xor_ctrl", 64'(alu_control), 64'h4);
      id_funct3 = 3'b110; step(); checkOutput("or_ctrl", 64'(alu_control), 64'h1);
      id_funct3 = 3'b111; id_funct7_b5 = 1'b1; step(); checkOutput("and_ctrl", 64'(alu_control), 64'h0);
      id_funct3 = 3'b000; id_funct7_b5 = 1'b0; step(); checkOutput("add_ctrl", 64'(alu_control), 64'h2);

      $display("[TB] Forwarding");
      applyStimulus(2'b10, 3'b000, 1'b0, 1'b0, 5'd7, 5'd8, 5'd10, 64'h1111, 64'h2222, 64'h0, 1'b1, 1'b0);
      ex_mem_rd = 5'd7; ex_mem_reg_write = 1'b1; ex_mem_result = 64'hAAAA;
      mem_wb_rd = 5'd7; mem_wb_reg_write = 1'b1; mem_wb_result = 64'hBBBB;
      step();
      checkOutput("fwd_prio_in1", alu_in1, 64'hAAAA);
      checkOutput("fwd_none_in2", alu_in2, 64'h2222);
      ex_mem_reg_write = 1'b0; #1;
      checkOutput("fwd_memwb_in1", alu_in1, 64'hBBBB);
      mem_wb_rd = 5'd8; #1;
      checkOutput("fwd_memwb_in2", alu_in2, 64'hBBBB);
      checkOutput("fwd_memwb_store", ex_store_data, 64'hBBBB);
      checkOutput("fwd_reg_in1", alu_in1, 64'h1111);
      ex_mem_rd = 5'd0; mem_wb_rd = 5'd0; ex_mem_reg_write = 1'b1; #1;
      checkOutput("fwd_rd0_in1", alu_in1, 64'h1111);
      applyStimulus(2'b10, 3'b000, 1'b0, 1'b0, 5'd0, 5'd8, 5'd10, 64'h5555, 64'h2222, 64'h0, 1'b1, 1'b0);
      step();
      checkOutput("fwd_x0_in1", alu_in1, 64'h5555);
      ex_mem_reg_write = 1'b0; mem_wb_reg_write = 1'b0;

      $display("[TB] Load-use");
      applyStimulus(2'b00, 3'b011, 1'b0, 1'b1, 5'd1, 5'd2, 5'd9, 64'h100, 64'h0, 64'd8, 1'b1, 1'b1);
      step();
      checkOutput("ld_memread", 64'(ex_mem_read), 64'd1);
      applyStimulus(2'b10, 3'b000, 1'b0, 1'b0, 5'd2, 5'd9, 5'd11, 64'd1, 64'd2, 64'd0, 1'b1, 1'b0);
      #1;
      checkOutput("lu_stall", 64'(load_use_stall), 64'd1);
      id_valid = 1'b0; #1;
      checkOutput("lu_nostall_invalid", 64'(load_use_stall), 64'd0);
      id_valid = 1'b1; #1;
      step();
      checkOutput("lu_valid", 64'(ex_valid), 64'd0);
      checkOutput("lu_rw", 64'(ex_reg_write), 64'd0);
      checkOutput("lu_ctrl", 64'(alu_control), 64'd0);
      checkOutput("lu_stall_clear", 64'(load_use_stall), 64'd0);
      step();
      checkOutput("lu_resume", 64'(ex_rd), 64'd11);
      applyStimulus(2'b00, 3'b011, 1'b0, 1'b1, 5'd1, 5'd2, 5'd0, 64'h100, 64'h0, 64'd8, 1'b1, 1'b1);
      step();
      applyStimulus(2'b10, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd11, 64'd1, 64'd2, 64'd0, 1'b1, 1'b0);
      #1;
      checkOutput("lu_x0_nostall", 64'(load_use_stall), 64'd0);

      $display("[TB] Invalid slot");
      applyStimulus(2'b00, 3'b000, 1'b0, 1'b0, 5'd3, 5'd4, 5'd5, 64'd1, 64'd2, 64'd0, 1'b1, 1'b1);
      id_valid = 1'b0;
      step();
      checkOutput("inv_valid", 64'(ex_valid), 64'd0);
      checkOutput("inv_rw", 64'(ex_reg_write), 64'd0);
      checkOutput("inv_mr", 64'(ex_mem_read), 64'd0);

      $display("[TB] Hold and flush");
      applyStimulus(2'b10, 3'b100, 1'b0, 1'b0, 5'd12, 5'd13, 5'd14, 64'hF0, 64'h0F, 64'd0, 1'b1, 1'b0);
      step();
      ex_hold = 1'b1;
      applyStimulus(2'b10, 3'b110, 1'b0, 1'b0, 5'd15, 5'd16, 5'd17, 64'h77, 64'h88, 64'd0, 1'b1, 1'b0);
      step(); step();
      checkOutput("hold_ctrl", 64'(alu_control), 64'h4);
      checkOutput("hold_in1", alu_in1, 64'hF0);
      checkOutput("hold_in2", alu_in2, 64'h0F);
      checkOutput("hold_rd", 64'(ex_rd), 64'd14);
      checkOutput("hold_valid", 64'(ex_valid), 64'd1);
      flush = 1'b1;
      step();
      checkOutput("flush_valid", 64'(ex_valid), 64'd0);
      checkOutput("flush_ctrl", 64'(alu_control), 64'd0);
      checkOutput("flush_in1", alu_in1, 64'd0);
      checkOutput("flush_rd", 64'(ex_rd), 64'd0);
      flush = 1'b0; ex_hold = 1'b0;

      $display("[TB] Reset mid-stream");
      applyStimulus(2'b10, 3'b011, 1'b0, 1'b1, 5'd20, 5'd21, 5'd22, 64'h1234, 64'h5678, 64'h9A, 1'b1, 1'b1);
      step();
      checkOutput("pre_reset_valid", 64'(ex_valid), 64'd1);
      reset = 1'b1;
      step();
      checkOutput("rst_valid", 64'(ex_valid), 64'd0);
      checkOutput("rst_rw", 64'(ex_reg_write), 64'd0);
      checkOutput("rst_mr", 64'(ex_mem_read), 64'd0);
      checkOutput("rst_rd", 64'(ex_rd), 64'd0);
      checkOutput("rst_ctrl", 64'(alu_control), 64'd0);
      checkOutput("rst_in1", alu_in1, 64'd0);
      checkOutput("rst_in2", alu_in2, 64'd0);
      checkOutput("rst_store", ex_store_data, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
